// File: rtl/uc_multiciclo_pkg.sv
// rtl/uc_multiciclo_pkg.sv - shared opcodes, state encodings and control vector for uc_multiciclo
package uc_multiciclo_pkg;

    typedef enum logic [1:0] {
        S_EXEC  = 2'd0,
        S_WAIT2 = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // Grouped opcodes (LI..POP) only decode on bits [5:2]; the low two bits are operand bits.
    localparam logic [5:0] OP_LI   = 6'b100000;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b101000;
    localparam logic [5:0] OP_PUSH = 6'b101100;
    localparam logic [5:0] OP_POP  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b110100;
    localparam logic [5:0] OP_JZ   = 6'b110101;
    localparam logic [5:0] OP_JNZ  = 6'b110110;
    localparam logic [5:0] OP_JR   = 6'b110111;
    localparam logic [5:0] OP_CALL = 6'b111000;
    localparam logic [5:0] OP_RET  = 6'b111001;
    localparam logic [5:0] OP_NOP  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef struct packed {
        logic       s_inc;
        logic       salto_r;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op_alu;
        logic       mem_we;
        logic       mem_en;
        logic       mem_addr_sel;
        logic       sub_en;
        logic       sub_push;
        logic       sub_sel;
        logic       pd_en;
        logic       pd_push;
        logic       pd_sel;
        logic       pc_hold;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    // Quiet control vector: PC advances by one, nothing else enabled.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c       = '0;
        c.s_inc = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/uc_multiciclo_decoder.sv
// rtl/uc_multiciclo_decoder.sv - combinational opcode/state/z to control-vector decoder
// Purpose: pure decode of the current state and instruction into datapath controls,
//          next state, and the retire strobe for the instruction counter.
// Ports:   state, is_pop (two-cycle op is POP), wait_last (final wait cycle),
//          opcode, z -> ctrl, next_state, retire, next_is_pop
module uc_multiciclo_decoder
    import uc_multiciclo_pkg::*;
(
    input  state_t     state,
    input  logic       is_pop,
    input  logic       wait_last,
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output state_t     next_state,
    output logic       retire,
    output logic       next_is_pop
);

    always_comb begin
        ctrl        = ctrl_idle();
        next_state  = state;
        retire      = 1'b0;
        next_is_pop = is_pop;
        unique case (state)
            S_EXEC: begin
                retire = 1'b1;
                if (!opcode[5]) begin
                    ctrl.op_alu = opcode[4:2];
                    ctrl.we3    = 1'b1;
                    ctrl.wez    = 1'b1;
                end else if (opcode[5:2] == OP_LI[5:2]) begin
                    ctrl.s_inm = 1'b1;
                    ctrl.we3   = 1'b1;
                end else if (opcode[5:2] == OP_LD[5:2]) begin
                    ctrl.mem_en       = 1'b1;
                    ctrl.mem_addr_sel = 1'b1;
                    ctrl.pc_hold      = 1'b1;
                    retire            = 1'b0;
                    next_is_pop       = 1'b0;
                    next_state        = S_WAIT2;
                end else if (opcode[5:2] == OP_ST[5:2]) begin
                    ctrl.mem_en = 1'b1;
                    ctrl.mem_we = 1'b1;
                end else if (opcode[5:2] == OP_PUSH[5:2]) begin
                    ctrl.pd_en   = 1'b1;
                    ctrl.pd_push = 1'b1;
                end else if (opcode[5:2] == OP_POP[5:2]) begin
                    ctrl.pd_en   = 1'b1;
                    ctrl.pc_hold = 1'b1;
                    retire       = 1'b0;
                    next_is_pop  = 1'b1;
                    next_state   = S_WAIT2;
                end else begin
                    case (opcode)
                        OP_J:    ctrl.s_inc = 1'b0;
                        OP_JZ:   ctrl.s_inc = ~z;
                        OP_JNZ:  ctrl.s_inc = z;
                        OP_JR:   ctrl.salto_r = 1'b1;
                        OP_CALL: begin
                            ctrl.sub_en   = 1'b1;
                            ctrl.sub_push = 1'b1;
                            ctrl.s_inc    = 1'b0;
                        end
                        OP_RET: begin
                            ctrl.sub_en  = 1'b1;
                            ctrl.sub_sel = 1'b1;
                        end
                        OP_NOP:  ;
                        OP_HALT: begin
                            ctrl.pc_hold = 1'b1;
                            next_state   = S_HALT;
                        end
                        default: ctrl.illegal = 1'b1;
                    endcase
                end
            end
            S_WAIT2: begin
                // The pending instruction kind is latched on entry, so opcode is not consulted here.
                if (is_pop) begin
                    ctrl.pd_sel = 1'b1;
                end else begin
                    ctrl.mem_en       = 1'b1;
                    ctrl.mem_addr_sel = 1'b1;
                end
                ctrl.we3     = wait_last;
                ctrl.pc_hold = ~wait_last;
                if (wait_last) begin
                    retire     = 1'b1;
                    next_state = S_EXEC;
                end
            end
            S_HALT: begin
                ctrl.pc_hold = 1'b1;
                ctrl.halted  = 1'b1;
            end
            default: next_state = S_EXEC;
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multicycle control unit for the 8-bit/10-bit-PC datapath
// Purpose: holds the EXEC/WAIT2/HALT state and the retired-instruction counter,
//          drives all datapath controls from uc_multiciclo_decoder.
// Ports:   clk, reset (sync, active high), opcode[5:0], z in;
//          PC/ALU/register/memory/stack controls, pc_hold, halted, illegal, icount out.
module uc_multiciclo
    import uc_multiciclo_pkg::*;
#(
    parameter int ICNT_W   = 16,
    parameter int PUSH_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic              z,
    output logic              s_inc,
    output logic              selectorMuxSaltoR,
    output logic              s_inm,
    output logic              we3,
    output logic              wez,
    output logic [2:0]        op_alu,
    output logic              guardarMemoriaDatos,
    output logic              activarMemoria,
    output logic              selectorMuxDireccionMemoriaDatos,
    output logic              activarPilaSubRutinas,
    output logic              pushPilaSubRutinas,
    output logic              selectorMuxPilaSubRutinas,
    output logic              activarPilaDatos,
    output logic              pushPilaDatos,
    output logic              selectorMuxPilaDatos,
    output logic              pc_hold,
    output logic              halted,
    output logic              illegal,
    output logic [ICNT_W-1:0] icount
);

    state_t            state_q, state_d;
    logic              is_pop_q, is_pop_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ICNT_W-1:0] icount_q, icount_d;

    ctrl_t  dec_ctrl, ctrl;
    state_t dec_next;
    logic   dec_retire, dec_is_pop, wait_last;

    // Read data arrives PUSH_LAT cycles after the request; the register write lands on the last one.
    assign wait_last = (32'(wait_cnt_q) == 32'(PUSH_LAT - 1));

    uc_multiciclo_decoder u_decoder (
        .state       (state_q),
        .is_pop      (is_pop_q),
        .wait_last   (wait_last),
        .opcode      (opcode),
        .z           (z),
        .ctrl        (dec_ctrl),
        .next_state  (dec_next),
        .retire      (dec_retire),
        .next_is_pop (dec_is_pop)
    );

    always_comb begin
        state_d    = dec_next;
        is_pop_d   = dec_is_pop;
        wait_cnt_d = (state_q == S_WAIT2 && !wait_last) ? wait_cnt_q + 4'd1 : 4'd0;
        icount_d   = icount_q + {{(ICNT_W-1){1'b0}}, dec_retire};
        // Reset masks every control so an aborted LD/POP never writes the register file.
        ctrl = dec_ctrl;
        if (reset) begin
            ctrl = ctrl_idle();
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_EXEC;
            is_pop_q   <= 1'b0;
            wait_cnt_q <= 4'd0;
            icount_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_pop_q   <= is_pop_d;
            wait_cnt_q <= wait_cnt_d;
            icount_q   <= icount_d;
        end
    end

    assign s_inc                            = ctrl.s_inc;
    assign selectorMuxSaltoR                = ctrl.salto_r;
    assign s_inm                            = ctrl.s_inm;
    assign we3                              = ctrl.we3;
    assign wez                              = ctrl.wez;
    assign op_alu                           = ctrl.op_alu;
    assign guardarMemoriaDatos              = ctrl.mem_we;
    assign activarMemoria                   = ctrl.mem_en;
    assign selectorMuxDireccionMemoriaDatos = ctrl.mem_addr_sel;
    assign activarPilaSubRutinas            = ctrl.sub_en;
    assign pushPilaSubRutinas               = ctrl.sub_push;
    assign selectorMuxPilaSubRutinas        = ctrl.sub_sel;
    assign activarPilaDatos                 = ctrl.pd_en;
    assign pushPilaDatos                    = ctrl.pd_push;
    assign selectorMuxPilaDatos             = ctrl.pd_sel;
    assign pc_hold                          = ctrl.pc_hold;
    assign halted                           = ctrl.halted;
    assign illegal                          = ctrl.illegal;
    assign icount                           = icount_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - self-checking bench for uc_multiciclo against a behavioural model
module tb_uc_multiciclo;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode;
    logic          z;
    logic          s_inc, sr, s_inm, we3, wez;
    logic [2:0]    op_alu;
    logic          mem_we, mem_en, mem_sel;
    logic          sub_en, sub_push, sub_sel;
    logic          pd_en, pd_push, pd_sel;
    logic          pc_hold, halted, illegal;
    logic [CW-1:0] icount;

    int vectors = 0;
    int miscompares = 0;

    // Model: pending 0 = free, 1 = LD second cycle due, 2 = POP second cycle due.
    int            pending = 0;
    bit            stopped = 0;
    logic [CW-1:0] count = '0;
    logic [5:0]    last_op = 6'd0;

    always #5 clk = ~clk;

    uc_multiciclo #(.ICNT_W(CW), .PUSH_LAT(1)) dut (
        .clk                              (clk),
        .reset                            (reset),
        .opcode                           (opcode),
        .z                                (z),
        .s_inc                            (s_inc),
        .selectorMuxSaltoR                (sr),
        .s_inm                            (s_inm),
        .we3                              (we3),
        .wez                              (wez),
        .op_alu                           (op_alu),
        .guardarMemoriaDatos              (mem_we),
        .activarMemoria                   (mem_en),
        .selectorMuxDireccionMemoriaDatos (mem_sel),
        .activarPilaSubRutinas            (sub_en),
        .pushPilaSubRutinas               (sub_push),
        .selectorMuxPilaSubRutinas        (sub_sel),
        .activarPilaDatos                 (pd_en),
        .pushPilaDatos                    (pd_push),
        .selectorMuxPilaDatos             (pd_sel),
        .pc_hold                          (pc_hold),
        .halted                           (halted),
        .illegal                          (illegal),
        .icount                           (icount)
    );

    function automatic logic [19:0] exp_ctrl(input logic [5:0] op, input logic zz, input logic rst);
        logic       e_inc, e_sr, e_inm, e_we3, e_wez, e_mwe, e_men, e_msel;
        logic       e_sen, e_spush, e_ssel, e_pen, e_ppush, e_psel, e_hold, e_halt, e_ill;
        logic [2:0] e_alu;
        int         n;
        {e_sr, e_inm, e_we3, e_wez, e_mwe, e_men, e_msel, e_sen, e_spush} = '0;
        {e_ssel, e_pen, e_ppush, e_psel, e_hold, e_halt, e_ill} = '0;
        e_alu = 3'd0;
        e_inc = 1'b1;
        n = int'(op);
        if (rst) begin
            // only the PC-increment default survives reset
        end else if (stopped) begin
            e_hold = 1'b1;
            e_halt = 1'b1;
        end else if (pending == 1) begin
            e_men = 1'b1; e_msel = 1'b1; e_we3 = 1'b1;
        end else if (pending == 2) begin
            e_psel = 1'b1; e_we3 = 1'b1;
        end else if (n < 32) begin
            e_alu = 3'((n / 4) % 8); e_we3 = 1'b1; e_wez = 1'b1;
        end else if (n < 36) begin
            e_inm = 1'b1; e_we3 = 1'b1;
        end else if (n < 40) begin
            e_men = 1'b1; e_msel = 1'b1; e_hold = 1'b1;
        end else if (n < 44) begin
            e_men = 1'b1; e_mwe = 1'b1;
        end else if (n < 48) begin
            e_pen = 1'b1; e_ppush = 1'b1;
        end else if (n < 52) begin
            e_pen = 1'b1; e_hold = 1'b1;
        end else if (n == 52) e_inc = 1'b0;
        else if (n == 53) e_inc = !zz;
        else if (n == 54) e_inc = zz;
        else if (n == 55) e_sr = 1'b1;
        else if (n == 56) begin e_sen = 1'b1; e_spush = 1'b1; e_inc = 1'b0; end
        else if (n == 57) begin e_sen = 1'b1; e_ssel = 1'b1; end
        else if (n == 58) begin end
        else if (n == 63) e_hold = 1'b1;
        else e_ill = 1'b1;
        return {e_inc, e_sr, e_inm, e_we3, e_wez, e_alu, e_mwe, e_men, e_msel,
                e_sen, e_spush, e_ssel, e_pen, e_ppush, e_psel, e_hold, e_halt, e_ill};
    endfunction

    task automatic model_update(input logic [5:0] op, input logic rst);
        int n;
        n = int'(op);
        if (rst) begin
            pending = 0; stopped = 0; count = '0;
        end else if (stopped) begin
            // frozen until reset
        end else if (pending != 0) begin
            pending = 0; count = count + 1'b1;
        end else if (n >= 36 && n < 40) begin
            pending = 1;
        end else if (n >= 48 && n < 52) begin
            pending = 2;
        end else begin
            if (n == 63) stopped = 1;
            count = count + 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic zz, input logic rst, input string tag);
        logic [19:0] obs;
        @(negedge clk);
        opcode = op; z = zz; reset = rst; last_op = op;
        #1;
        obs = {s_inc, sr, s_inm, we3, wez, op_alu, mem_we, mem_en, mem_sel,
               sub_en, sub_push, sub_sel, pd_en, pd_push, pd_sel, pc_hold, halted, illegal};
        check({tag, "_ctrl"}, 32'(obs), 32'(exp_ctrl(op, zz, rst)));
        @(posedge clk);
        model_update(op, rst);
        #1;
        check({tag, "_icount"}, 32'(icount), 32'(count));
    endtask

    initial begin
        logic [5:0] rop;
        logic       rz, rr;
        reset = 1'b1; opcode = 6'd0; z = 1'b0;
        repeat (3) step(6'b000000, 1'b0, 1'b1, "reset");
        step(6'b000100, 1'b0, 1'b0, "alu001");
        step(6'b100100, 1'b0, 1'b0, "ld_c1");
        step(6'b100100, 1'b0, 1'b0, "ld_c2");
        step(6'b110101, 1'b1, 1'b0, "jz_z1");
        step(6'b110101, 1'b0, 1'b0, "jz_z0");
        step(6'b110110, 1'b0, 1'b0, "jnz_z0");
        step(6'b111000, 1'b0, 1'b0, "call");
        step(6'b111001, 1'b0, 1'b0, "ret");
        step(6'b111111, 1'b0, 1'b0, "halt");
        for (int i = 0; i < 10; i++) step(6'($urandom_range(0, 63)), 1'($urandom), 1'b0, "halted");
        step(6'b111010, 1'b0, 1'b1, "halt_reset");
        step(6'b110000, 1'b0, 1'b0, "pop_c1");
        step(6'b110000, 1'b0, 1'b1, "pop_abort");
        step(6'b111010, 1'b0, 1'b0, "after_abort");
        step(6'b111100, 1'b0, 1'b0, "illegal");
        step(6'b111010, 1'b0, 1'b0, "illegal_clear");
        for (int i = 0; i < 20; i++) step(6'b111010, 1'b0, 1'b0, "wrap");
        for (int i = 0; i < 400; i++) begin
            rop = (pending != 0) ? last_op : 6'($urandom_range(0, 63));
            rz  = 1'($urandom);
            rr  = ($urandom_range(0, 29) == 0);
            step(rop, rz, rr, "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
